tdm_mux_4x1: RTL and testbench
==============================

TDM_MUX_4X1 -- requirements
Module: tdm_mux_4x1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, which sets the channel data width in bits.
REQ-002 The block SHALL have parameter CH, default 4, which sets the channel count; only the value 4 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: run request for the time-division frame sequencer.
REQ-006 The block SHALL have port in_data, input, CH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, CH bits: per-channel load request.
REQ-008 The block SHALL have port in_ready, output, CH bits: per-channel holding register empty.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: multiplexed data for the current slot.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data carries a real sample this cycle.
REQ-011 The block SHALL have port out_slot, output, 2 bits: channel index of the slot being presented.
REQ-012 The block SHALL have port frame, output, 1 bit: high while slot 0 is presented.

Function
REQ-013 Each channel SHALL have one WIDTH-bit holding register plus a full flag; in_ready[k] SHALL equal the inverse of full[k], with no combinational path from any input.
REQ-014 When in_valid[k] and in_ready[k] are both high on an edge, data SHALL be captured and full[k] SHALL be set.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DRAIN.
REQ-016 In IDLE, en=1 SHALL move the FSM to RUN with the slot counter at 0.
REQ-017 In RUN, the slot counter SHALL increment by 1 every cycle, modulo 4 (3 wraps to 0).
REQ-018 In RUN, en=0 SHALL move the FSM to DRAIN.
REQ-019 DRAIN SHALL continue stepping slots until slot 3 has been presented, then return to IDLE, so frames are never truncated.
REQ-020 In DRAIN, en=1 SHALL return the FSM to RUN without disturbing the slot counter.
REQ-021 Outputs SHALL be registered, with 1-cycle latency: the cycle after slot s is sampled, out_slot=s and frame=(s==0).
REQ-022 If full[s] was set when slot s was sampled, the output register SHALL show out_data=hold[s] and out_valid=1, and full[s] SHALL clear on that edge.
REQ-023 If full[s] was not set when slot s was sampled, the output register SHALL show out_valid=0 and out_data=0 (idle slot).
REQ-024 If a drain of channel k and a load on channel k fall on the same edge, the drain SHALL win and the load SHALL be blocked, because in_ready[k] is already 0.
REQ-025 While in IDLE: out_valid=0, frame=0, out_slot=0, out_data=0; the holding registers SHALL keep loading and SHALL retain their contents.
REQ-026 Unused slots SHALL never repeat or duplicate a sample: each loaded word SHALL appear on out_data exactly once.

Reset
REQ-027 When rst=1 on an edge, the FSM SHALL go to IDLE and the slot counter SHALL go to 0.
REQ-028 When rst=1 on an edge, all full flags SHALL clear, so in_ready resets to all-ones.
REQ-029 When rst=1 on an edge, out_data, out_valid, out_slot and frame SHALL all reset to 0.
REQ-030 Reset asserted mid-frame SHALL discard held data without emitting it, and rst SHALL take priority over en and in_valid.

Structure
REQ-031 State encodings (IDLE=0, RUN=1, DRAIN=2) and the slot-count constant SHALL live in the shared package tdm_pkg.
REQ-032 The per-channel holding register plus full flag SHALL be one sub-module, tdm_hold_reg, instantiated CH times; the top level SHALL contain the FSM, the slot counter and the output mux.

Verification
REQ-033 Directed scenario: rst=1, then in_valid=4'b1111 with data 11,22,33,44 and en=1 -> on the following cycles out_data=11,22,33,44 with out_valid=1, out_slot=0..3, and frame high on the first of these cycles only.
REQ-034 Directed scenario: only channel 2 loaded with 0xA5 while in RUN -> out_valid=1 only when out_slot=2; every other slot shows out_valid=0 and out_data=0.
REQ-035 Directed scenario: en dropped while slot 1 is being sampled -> out_slot steps 1,2,3 and then the FSM returns to IDLE; no frame pulse follows.
REQ-036 Directed scenario: en re-asserted while in DRAIN at slot 2 -> slot 3 is followed by slot 0 with frame=1, and no gap cycle.
REQ-037 Directed scenario: in_valid[0] held high while slot 0 drains -> in_ready[0] is 0 on the drain edge, the new word is loaded one cycle later and is emitted in the next frame.
REQ-038 Directed scenario: rst pulsed while all channels are full -> all outputs are 0 on the next cycle, in_ready=4'b1111, and no held word is ever emitted.

Source files
------------

// File: rtl/tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_pkg : shared FSM encodings and slot constants for tdm_mux_4x1     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tdm_pkg;

   localparam int unsigned c_SLOT_COUNT = 4;
   localparam logic [1:0]  c_LAST_SLOT  = 2'(c_SLOT_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   function automatic logic [1:0] next_slot(input logic [1:0] slot);
      return (slot == c_LAST_SLOT) ? 2'd0 : slot + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_hold_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_hold_reg : one-word channel holding register with full flag      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdm_hold_reg
   import tdm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             drain_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;

   // A full register ignores loads, so a drain and a load on the same edge
   // resolves to the drain; the new word lands one cycle later.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (full_q) begin
         if (drain_i) begin
            full_d = 1'b0;
         end
      end else if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule
`default_nettype wire

// File: rtl/tdm_mux_4x1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_mux_4x1 : four-channel time-division multiplexer, registered out |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tdm_mux_4x1
   import tdm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CH    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CH*WIDTH-1:0] in_data,
   input  logic [CH-1:0]       in_valid,
   output logic [CH-1:0]       in_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic                out_valid,
   output logic [1:0]          out_slot,
   output logic                frame
);

   state_e           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       out_slot_q, out_slot_d;
   logic             frame_q, frame_d;

   logic             w_active;
   logic [CH-1:0]    w_full;
   logic [WIDTH-1:0] w_hold [CH];

   assign w_active = (state_q != IDLE);

   generate
      for (genvar k = 0; k < CH; k++) begin : g_ch
         localparam logic [1:0] c_IDX = 2'(k);

         tdm_hold_reg #(
            .WIDTH (WIDTH)
         ) u_hold (
            .clk     (clk),
            .rst     (rst),
            .load_i  (in_valid[k]),
            .drain_i (w_active && (slot_q == c_IDX)),
            .data_i  (in_data[k*WIDTH +: WIDTH]),
            .data_o  (w_hold[k]),
            .full_o  (w_full[k])
         );

         assign in_ready[k] = ~w_full[k];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         slot_q      <= 2'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_slot_q  <= 2'd0;
         frame_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_slot_q  <= out_slot_d;
         frame_q     <= frame_d;
      end
   end

   // Dropping en only ends the run at a frame boundary; a partial frame
   // always finishes through slot 3 first.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      case (state_q)
         IDLE: begin
            slot_d = 2'd0;
            if (en) begin
               state_d = RUN;
            end
         end
         RUN: begin
            slot_d = next_slot(slot_q);
            if (!en) begin
               state_d = (slot_q == c_LAST_SLOT) ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            slot_d = next_slot(slot_q);
            if (en) begin
               state_d = RUN;
            end else if (slot_q == c_LAST_SLOT) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            slot_d  = 2'd0;
         end
      endcase
   end

   always_comb begin
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_slot_d  = 2'd0;
      frame_d     = 1'b0;
      if (w_active) begin
         out_slot_d = slot_q;
         frame_d    = (slot_q == 2'd0);
         if (w_full[slot_q]) begin
            out_valid_d = 1'b1;
            out_data_d  = w_hold[slot_q];
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_slot  = out_slot_q;
   assign frame     = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux_4x1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tdm_mux_4x1 : scoreboard bench with directed frame scenarios      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tdm_mux_4x1;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [1:0]  out_slot;
   logic        frame;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       valid;
      logic [1:0] slot;
      logic       frame;
      logic [3:0] ready;
   } exp_t;

   exp_t sb [$];

   tdm_mux_4x1 #(
      .WIDTH (8),
      .CH    (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_slot  (out_slot),
      .frame     (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: samples inputs at each edge and queues the expected
   // post-edge outputs.
   int         m_state = 0;
   int         m_slot  = 0;
   bit [3:0]   m_full  = 4'h0;
   logic [7:0] m_hold [4];
   bit [3:0]   m_nf;
   exp_t       m_e;

   always @(posedge clk) begin
      m_e.data  = 8'h00;
      m_e.valid = 1'b0;
      m_e.slot  = 2'd0;
      m_e.frame = 1'b0;
      if (rst) begin
         m_state = 0;
         m_slot  = 0;
         m_full  = 4'h0;
      end else begin
         m_nf = m_full;
         if (m_state != 0) begin
            m_e.slot  = 2'(m_slot);
            m_e.frame = (m_slot == 0);
            if (m_full[m_slot]) begin
               m_e.valid    = 1'b1;
               m_e.data     = m_hold[m_slot];
               m_nf[m_slot] = 1'b0;
            end
         end
         for (int k = 0; k < 4; k++) begin
            if (in_valid[k] && !m_full[k]) begin
               m_nf[k]   = 1'b1;
               m_hold[k] = in_data[k*8 +: 8];
            end
         end
         case (m_state)
            0: begin
               m_slot = 0;
               if (en) m_state = 1;
            end
            1: begin
               if (!en) m_state = (m_slot == 3) ? 0 : 2;
               m_slot = (m_slot + 1) % 4;
            end
            default: begin
               if (en) m_state = 1;
               else if (m_slot == 3) m_state = 0;
               m_slot = (m_slot + 1) % 4;
            end
         endcase
         m_full = m_nf;
      end
      m_e.ready = ~m_full;
      sb.push_back(m_e);
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("sb_data",  {24'h0, out_data}, {24'h0, e.data});
         check("sb_valid", {31'h0, out_valid}, {31'h0, e.valid});
         check("sb_slot",  {30'h0, out_slot}, {30'h0, e.slot});
         check("sb_frame", {31'h0, frame}, {31'h0, e.frame});
         check("sb_ready", {28'h0, in_ready}, {28'h0, e.ready});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   logic [7:0] seq33 [4];
   int         cnt;

   initial begin
      seq33    = '{8'd11, 8'd22, 8'd33, 8'd44};
      rst      = 1'b1;
      en       = 1'b0;
      in_valid = 4'h0;
      in_data  = 32'h0;
      tick();
      tick();
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_data",  {24'h0, out_data}, 32'h0);
      check("rst_ready", {28'h0, in_ready}, 32'hF);

      // Full frame of four samples
      rst      = 1'b0;
      en       = 1'b1;
      in_valid = 4'hF;
      in_data  = {8'd44, 8'd33, 8'd22, 8'd11};
      tick();
      in_valid = 4'h0;
      check("s33_idle_valid", {31'h0, out_valid}, 32'h0);
      check("s33_loaded",     {28'h0, in_ready}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("s33_data",  {24'h0, out_data}, {24'h0, seq33[i]});
         check("s33_valid", {31'h0, out_valid}, 32'h1);
         check("s33_slot",  {30'h0, out_slot}, i);
         check("s33_frame", {31'h0, frame}, (i == 0) ? 32'h1 : 32'h0);
      end
      repeat (4) tick();

      // Only channel 2 loaded while running
      in_valid = 4'b0100;
      in_data  = 32'h00A5_0000;
      tick();
      in_valid = 4'h0;
      check("s34_slot0",  {30'h0, out_slot}, 32'h0);
      check("s34_valid0", {31'h0, out_valid}, 32'h0);
      cnt = 0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("s34_slot",  {30'h0, out_slot}, i % 4);
         check("s34_valid", {31'h0, out_valid}, (i == 2) ? 32'h1 : 32'h0);
         check("s34_data",  {24'h0, out_data}, (i == 2) ? 32'hA5 : 32'h0);
         if (out_valid) cnt++;
      end
      check("s34_once", cnt, 1);

      // en dropped while slot 1 is sampled
      en = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("s35_slot", {30'h0, out_slot}, i);
      end
      tick();
      check("s35_idle_frame", {31'h0, frame}, 32'h0);
      check("s35_idle_slot",  {30'h0, out_slot}, 32'h0);
      tick();
      check("s35_idle_frame2", {31'h0, frame}, 32'h0);

      // en re-asserted in DRAIN at slot 2
      en = 1'b1;
      tick();
      tick();
      check("s36_frame0", {31'h0, frame}, 32'h1);
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      check("s36_slot2", {30'h0, out_slot}, 32'h2);
      tick();
      check("s36_slot3", {30'h0, out_slot}, 32'h3);
      tick();
      check("s36_wrap_slot",  {30'h0, out_slot}, 32'h0);
      check("s36_wrap_frame", {31'h0, frame}, 32'h1);

      // Load blocked on the drain edge of channel 0
      in_valid = 4'b0001;
      in_data  = 32'h0000_005A;
      tick();
      in_data  = 32'h0000_006B;
      tick();
      tick();
      check("s37_ready_before_drain", {31'h0, in_ready[0]}, 32'h0);
      tick();
      check("s37_drain_data",  {24'h0, out_data}, 32'h5A);
      check("s37_ready_after", {31'h0, in_ready[0]}, 32'h1);
      tick();
      check("s37_reload", {31'h0, in_ready[0]}, 32'h0);
      in_valid = 4'h0;
      tick();
      tick();
      tick();
      check("s37_next_frame_data",  {24'h0, out_data}, 32'h6B);
      check("s37_next_frame_valid", {31'h0, out_valid}, 32'h1);

      // Reset with every channel full
      in_valid = 4'hF;
      in_data  = 32'h7473_7271;
      tick();
      check("s38_all_full", {28'h0, in_ready}, 32'h0);
      in_valid = 4'h0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      check("s38_data",  {24'h0, out_data}, 32'h0);
      check("s38_valid", {31'h0, out_valid}, 32'h0);
      check("s38_slot",  {30'h0, out_slot}, 32'h0);
      check("s38_frame", {31'h0, frame}, 32'h0);
      check("s38_ready", {28'h0, in_ready}, 32'hF);
      cnt = 0;
      repeat (6) begin
         tick();
         if (out_valid) cnt++;
      end
      check("s38_no_emit", cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
